demux_1xn_stream: RTL and testbench
===================================

Name: demux_1xn_stream

Overview:
- Parametrised, registered 1-to-NUM_CH stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Successor to the combinational 1x2 demux. Adds generic width and channel count, a per-channel single-entry output buffer with backpressure, a broadcast mode, and detection of out-of-range selects.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_CH, 4, number of output channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver to all channels; in_sel is ignored.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  NUM_CH  per-channel beat valid.
- out_ready  input  NUM_CH  per-channel consumer ready.
- err_sel  output  1  one-cycle pulse when a beat with an out-of-range select is dropped.
- drop_cnt  output  8  saturating count of dropped beats.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0. While rst_n is low, in_ready = 0. Reset mid-transfer discards all buffered beats.
- Each channel has one holding register (slot) plus a full flag. out_valid[k] equals full[k].
- A channel is free when either of these holds:
  - !full[k]
  - out_ready[k] is 1, meaning the slot drains this cycle.
- in_ready is combinational and is computed as follows:
  - in_bcast = 1: in_ready = AND of free[k] over all k.
  - in_bcast = 0 and in_sel < NUM_CH: in_ready = free[in_sel].
  - in_bcast = 0 and in_sel >= NUM_CH: in_ready = 1, so the beat is always sunk.
  - in_ready must not depend on in_valid.
- Accept occurs when in_valid and in_ready are both 1 at a rising edge.
  - Unicast: slot[in_sel] is loaded with in_data and full is set. out_valid rises on the next cycle, giving latency of 1 clock.
  - Broadcast: every slot is loaded in the same edge and all out_valid bits rise together.
  - Out-of-range select: no slot changes. err_sel is 1 for exactly the next cycle. drop_cnt increments and holds at 255.
- Drain: out_valid[k] and out_ready[k] both 1 at an edge clears full[k], unless the same edge refills that slot. On a refill, full stays 1 and out_data[k] takes the new beat, so back-to-back throughput is 1 beat per clock per channel.
- While out_valid[k] = 1 and out_ready[k] = 0, out_data[k] must hold stable. Once raised, out_valid[k] must not drop before the handshake completes.
- Channels are independent. Draining channel j never affects channel k.
- Values of out_data are unspecified-but-stable when out_valid = 0. The RTL holds the last value.
- No X propagation. in_sel values >= NUM_CH are legal inputs and are handled by the drop path.
- NUM_CH not a power of two: the unused select codes take the drop path.

Test Plan:
- Reset then idle: assert rst_n = 0 asynchronously mid-cycle -> out_valid = 4'b0000, drop_cnt = 0, err_sel = 0 immediately. After release with all out_ready = 1, in_ready = 1.
- Unicast, all ready: send 0xA5 sel=2, then 0x3C sel=0 on consecutive cycles -> out_valid = 4'b0100 with ch2 = 0xA5, then 4'b0001 with ch0 = 0x3C. Each has 1-cycle latency; in_ready is held 1 throughout.
- Backpressure:
  - out_ready[1] = 0. Send 0x11 sel=1, then 0x22 sel=1 -> first beat accepted; in_ready = 0 for the second while ch1 holds 0x11 stable.
  - Raise out_ready[1] -> 0x11 drains and 0x22 is accepted on the same edge. Next cycle ch1 = 0x22 with out_valid[1] still 1.
- Broadcast blocking: ch3 full with out_ready[3] = 0, then in_bcast = 1 with data 0x77 -> in_ready = 0 and no slot changes. Release ch3 -> all four channels show 0x77 together one cycle after the accept.
- Out-of-range select: NUM_CH = 3, SEL_W = 2, send sel=3 for 300 consecutive beats -> in_ready = 1 each cycle, err_sel pulses each following cycle, no out_valid rises, drop_cnt saturates at 255.
- Reset mid-operation: fill all slots, then pulse rst_n low for 1 ns -> all out_valid = 0 immediately. After release, a fresh beat 0x5A sel=0 appears on ch0 only.

Source files
------------

// File: rtl/demux_1xn_stream_if.sv
// Stream bundle between one producer, the demux and NUM_CH consumers.
interface demux_1xn_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2
);
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_bcast;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic                     err_sel;
  logic [7:0]               drop_cnt;

  // Demux side
  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_sel, drop_cnt
  );

  // Producer/consumer side
  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_sel, drop_cnt
  );
endinterface

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-NUM_CH stream demux with one holding slot per channel,
// broadcast, and a drop path for out-of-range selects.
module demux_1xn_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_1xn_stream_if.slave    bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BUS_W = NUM_CH * DATA_W;

  logic [NUM_CH-1:0] r_full;
  logic [BUS_W-1:0]  r_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_load;
  logic              w_in_range;
  logic              w_ready;
  logic              w_accept;
  logic              w_drop;

  // Slot availability, select decode and acceptance (independent of in_valid for ready)
  always_comb begin
    w_free     = '0;
    w_hit      = '0;
    w_load     = '0;
    w_ready    = 1'b0;
    w_in_range = (32'(bus.in_sel) < NUM_CH);
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_free[k] = ~r_full[k] | bus.out_ready[k];
      w_hit[k]  = (32'(bus.in_sel) == k);
    end
    if (!rst_n) begin
      w_ready = 1'b0;
    end else if (bus.in_bcast) begin
      w_ready = &w_free;
    end else if (w_in_range) begin
      w_ready = |(w_free & w_hit);
    end else begin
      w_ready = 1'b1;
    end
    w_accept = bus.in_valid & w_ready;
    w_drop   = w_accept & ~bus.in_bcast & ~w_in_range;
    if (w_accept) begin
      w_load = bus.in_bcast ? '1 : w_hit;
    end
  end

  // Per-channel slot load/drain; a refill on the draining edge keeps the slot full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_data <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (w_load[k]) begin
          r_full[k]                 <= 1'b1;
          r_data[k*DATA_W +: DATA_W] <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          r_full[k] <= 1'b0;
        end
      end
    end
  end

  // Drop reporting: one-cycle error pulse and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_full;
  assign bus.err_sel   = r_err;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_demux_1xn_stream.sv
// Randomized and directed checks of demux_1xn_stream against a slot-level model.
module tb_demux_1xn_stream;
  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 2;
  localparam int unsigned NCH3 = 3;

  logic clk;
  logic rst_n;

  demux_1xn_stream_if #(.DATA_W(DW), .NUM_CH(NCH),  .SEL_W(SW)) if4 ();
  demux_1xn_stream_if #(.DATA_W(DW), .NUM_CH(NCH3), .SEL_W(SW)) if3 ();

  demux_1xn_stream #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
  );
  demux_1xn_stream #(.DATA_W(DW), .NUM_CH(NCH3), .SEL_W(SW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: what each channel currently holds, plus drop bookkeeping
  bit       m_full [NCH];
  bit [7:0] m_slot [NCH];
  bit       m_err;
  int       m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_full[k] = 1'b0;
      m_slot[k] = 8'h00;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // A channel can take a beat if empty or if its consumer takes the old one now
  function automatic bit exp_ready(input bit bc, input int sel, input bit [NCH-1:0] ordy);
    bit all_free;
    all_free = 1'b1;
    for (int k = 0; k < NCH; k++)
      if (m_full[k] && !ordy[k]) all_free = 1'b0;
    if (bc) return all_free;
    if (sel >= NCH) return 1'b1;
    return !m_full[sel] || ordy[sel];
  endfunction

  task automatic check_outputs(input string tag);
    bit [NCH-1:0] ev;
    for (int k = 0; k < NCH; k++) ev[k] = m_full[k];
    chk({tag, "_valid"}, 64'(if4.out_valid), 64'(ev));
    for (int k = 0; k < NCH; k++)
      if (m_full[k]) chk({tag, "_data"}, 64'(if4.out_data[k*DW +: DW]), 64'(m_slot[k]));
    chk({tag, "_err"}, 64'(if4.err_sel), 64'(m_err));
    chk({tag, "_cnt"}, 64'(if4.drop_cnt), 64'(m_cnt));
  endtask

  // One clock: drive at edge+1, check ready, clock, update model, check registered outputs
  task automatic cycle(input bit v, input int sel, input bit bc, input bit [7:0] d,
                       input bit [NCH-1:0] ordy, output bit rdy);
    bit er;
    bit acc;
    if4.in_valid  = v;
    if4.in_sel    = SW'(sel);
    if4.in_bcast  = bc;
    if4.in_data   = d;
    if4.out_ready = ordy;
    #1;
    er  = exp_ready(bc, sel, ordy);
    rdy = if4.in_ready;
    chk("in_ready", 64'(rdy), 64'(er));
    @(posedge clk);
    acc   = v && er;
    m_err = acc && !bc && (sel >= NCH);
    if (m_err && m_cnt < 255) m_cnt++;
    for (int k = 0; k < NCH; k++) begin
      if (acc && (bc || sel == k)) begin
        m_full[k] = 1'b1;
        m_slot[k] = d;
      end else if (ordy[k]) begin
        m_full[k] = 1'b0;
      end
    end
    #1;
    check_outputs("step");
  endtask

  bit rdy;

  initial begin
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.in_sel = '0; if4.in_bcast = 1'b0; if4.in_data = '0; if4.out_ready = '1;
    if3.in_valid = 1'b0; if3.in_sel = '0; if3.in_bcast = 1'b0; if3.in_data = '0; if3.out_ready = '1;
    model_reset();
    #12;
    chk("rst_valid", 64'(if4.out_valid), 64'h0);
    chk("rst_ready", 64'(if4.in_ready), 64'h0);
    chk("rst_cnt",   64'(if4.drop_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(if4.in_ready), 64'h1);

    // A few beats, then an asynchronous reset in the middle of the cycle
    cycle(1, 1, 0, 8'h42, 4'b0000, rdy);
    cycle(1, 3, 0, 8'h43, 4'b0000, rdy);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 64'(if4.out_valid), 64'h0);
    chk("async_rst_err",   64'(if4.err_sel),   64'h0);
    chk("async_rst_cnt",   64'(if4.drop_cnt),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unicast with all consumers ready
    cycle(1, 2, 0, 8'hA5, 4'b1111, rdy);
    chk("uni_rdy0", 64'(rdy), 64'h1);
    chk("uni_v0", 64'(if4.out_valid), 64'b0100);
    chk("uni_d2", 64'(if4.out_data[2*DW +: DW]), 64'hA5);
    cycle(1, 0, 0, 8'h3C, 4'b1111, rdy);
    chk("uni_rdy1", 64'(rdy), 64'h1);
    chk("uni_v1", 64'(if4.out_valid), 64'b0001);
    chk("uni_d0", 64'(if4.out_data[0 +: DW]), 64'h3C);
    cycle(0, 0, 0, 8'h00, 4'b1111, rdy);

    // Backpressure on ch1, then drain and refill on the same edge
    cycle(1, 1, 0, 8'h11, 4'b1101, rdy);
    chk("bp_acc", 64'(rdy), 64'h1);
    cycle(1, 1, 0, 8'h22, 4'b1101, rdy);
    chk("bp_block", 64'(rdy), 64'h0);
    chk("bp_hold", 64'(if4.out_data[1*DW +: DW]), 64'h11);
    cycle(1, 1, 0, 8'h22, 4'b1111, rdy);
    chk("bp_refill_rdy", 64'(rdy), 64'h1);
    chk("bp_refill_v", 64'(if4.out_valid[1]), 64'h1);
    chk("bp_refill_d", 64'(if4.out_data[1*DW +: DW]), 64'h22);
    cycle(0, 0, 0, 8'h00, 4'b1111, rdy);

    // Broadcast blocked by a stalled ch3, then released
    cycle(1, 3, 0, 8'h99, 4'b0111, rdy);
    cycle(1, 0, 1, 8'h77, 4'b0111, rdy);
    chk("bc_block", 64'(rdy), 64'h0);
    chk("bc_block_v", 64'(if4.out_valid), 64'b1000);
    cycle(1, 0, 1, 8'h77, 4'b1111, rdy);
    chk("bc_rdy", 64'(rdy), 64'h1);
    chk("bc_v", 64'(if4.out_valid), 64'b1111);
    chk("bc_d", 64'(if4.out_data), 64'h77777777);
    cycle(0, 0, 0, 8'h00, 4'b1111, rdy);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit [NCH-1:0] ordy;
      for (int k = 0; k < NCH; k++) ordy[k] = ($urandom_range(0, 9) < 7);
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)),
            $urandom_range(0, 7) == 0, 8'($urandom), ordy, rdy);
    end

    // Fill every slot, then a short reset pulse discards them
    cycle(1, 0, 1, 8'hEE, 4'b1111, rdy);
    cycle(0, 0, 0, 8'h00, 4'b0000, rdy);
    chk("fill_v", 64'(if4.out_valid), 64'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_v", 64'(if4.out_valid), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 8'h5A, 4'b1111, rdy);
    chk("post_rst_v", 64'(if4.out_valid), 64'b0001);
    chk("post_rst_d", 64'(if4.out_data[0 +: DW]), 64'h5A);
    cycle(0, 0, 0, 8'h00, 4'b1111, rdy);

    // 3-channel instance: select 3 is unused and every such beat is dropped
    chk("nch3_cnt0", 64'(if3.drop_cnt), 64'h0);
    for (int i = 0; i < 300; i++) begin
      if3.in_valid  = 1'b1;
      if3.in_sel    = 2'd3;
      if3.in_bcast  = 1'b0;
      if3.in_data   = 8'($urandom);
      if3.out_ready = 3'b111;
      #1;
      chk("drop_rdy", 64'(if3.in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk("drop_err", 64'(if3.err_sel), 64'h1);
      chk("drop_v",   64'(if3.out_valid), 64'h0);
      chk("drop_cnt", 64'(if3.drop_cnt), 64'((i + 1 > 255) ? 255 : i + 1));
    end
    if3.in_valid = 1'b1;
    if3.in_sel   = 2'd1;
    if3.in_data  = 8'hC3;
    @(posedge clk);
    #1;
    if3.in_valid = 1'b0;
    chk("nch3_err_clr", 64'(if3.err_sel), 64'h0);
    chk("nch3_v1", 64'(if3.out_valid), 64'b010);
    chk("nch3_d1", 64'(if3.out_data[1*DW +: DW]), 64'hC3);
    chk("nch3_cnt_sat", 64'(if3.drop_cnt), 64'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
